// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronised rxd, 16x-oversampled deframing, LSB first.
// Build macro UART_RX_PARITY_EN adds an even-parity bit (8E1); default is 8N1.
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_uart,
  input  logic                 enable_rx,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] d_out,
  output logic                 rx_done,
  output logic                 receiving,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned IW = $clog2(DATA_BITS);
  localparam int unsigned BW = IW + 1;
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state, state_nxt;
  logic                 rxd_m, rxd_s, rxd_p;
  logic                 fall;
  logic [TW-1:0]        tick_cnt, tick_nxt;
  logic [BW-1:0]        bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt, dout_nxt;
  logic                 done_nxt, ferr_nxt, perr_nxt, recv_nxt;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, par_nxt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_p <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_p <= rxd_s;
    end
  end

  assign fall = rxd_p & ~rxd_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      d_out      <= '0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      receiving  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      tick_cnt   <= tick_nxt;
      bit_cnt    <= bit_nxt;
      shift      <= shift_nxt;
      d_out      <= dout_nxt;
      rx_done    <= done_nxt;
      frame_err  <= ferr_nxt;
      parity_err <= perr_nxt;
      receiving  <= recv_nxt;
`ifdef UART_RX_PARITY_EN
      par_bit    <= par_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    dout_nxt  = d_out;
    done_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
    perr_nxt  = 1'b0;
    recv_nxt  = receiving;
`ifdef UART_RX_PARITY_EN
    par_nxt   = par_bit;
`endif
    case (state)
      IDLE: begin
        tick_nxt = '0;
        bit_nxt  = '0;
        recv_nxt = 1'b0;
        if (fall) state_nxt = START;
      end
      START: begin
        if (baud_uart) begin
          if (tick_cnt == HALF_LAST) begin
            tick_nxt = '0;
            if (rxd_s) begin
              state_nxt = IDLE;
            end else begin
              recv_nxt  = 1'b1;
              state_nxt = DATA;
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (baud_uart) begin
          if (tick_cnt == FULL_LAST) begin
            tick_nxt = '0;
            shift_nxt[bit_cnt[IW-1:0]] = rxd_s;
            if (bit_cnt == BIT_LAST) begin
              bit_nxt = '0;
`ifdef UART_RX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end else begin
              bit_nxt = bit_cnt + 1'b1;
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_uart) begin
          if (tick_cnt == FULL_LAST) begin
            tick_nxt  = '0;
            par_nxt   = rxd_s;
            state_nxt = STOP;
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (baud_uart) begin
          if (tick_cnt == FULL_LAST) begin
            tick_nxt  = '0;
            state_nxt = IDLE;
            recv_nxt  = 1'b0;
            dout_nxt  = shift;
            done_nxt  = rxd_s;
            ferr_nxt  = ~rxd_s;
`ifdef UART_RX_PARITY_EN
            perr_nxt  = ^{shift, par_bit};
`endif
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Disable overrides everything except the held output byte.
    if (!enable_rx) begin
      state_nxt = IDLE;
      tick_nxt  = '0;
      bit_nxt   = '0;
      recv_nxt  = 1'b0;
      done_nxt  = 1'b0;
      ferr_nxt  = 1'b0;
      perr_nxt  = 1'b0;
      dout_nxt  = d_out;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: vector table, hand-written corner cases and random frames
// scored against a frame-level model (baud tick every 4 clk, 1 bit = 64 clk).
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int BIT_CLK = 64;
  localparam int NB      = PAR_EN ? 10 : 9;

  logic       clk = 1'b0;
  logic       rst, baud_uart, enable_rx, rxd;
  logic [7:0] d_out;
  logic       rx_done, receiving, frame_err, parity_err;

  uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .baud_uart(baud_uart), .enable_rx(enable_rx), .rxd(rxd),
    .d_out(d_out), .rx_done(rx_done), .receiving(receiving),
    .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         done;
    bit         ferr;
    bit         perr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    bit         par_bad;
    bit         stop;
    int         gap;
    logic [7:0] exp_d;
    bit         exp_done;
    bit         exp_ferr;
    bit         exp_perr;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  bit   prev_recv = 1'b0;
  bit   recv_seen = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;
  int   lat;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Frame-level reference: outcome follows directly from what was put on the wire.
  function automatic exp_t model(input logic [7:0] data, input bit par_bad, input bit stop);
    exp_t e;
    int   ones;
    bit   sent_par;
    ones     = $countones(data);
    sent_par = bit'(ones % 2) ^ par_bad;
    e.data   = data;
    e.done   = stop;
    e.ferr   = !stop;
    e.perr   = PAR_EN && (((ones + int'(sent_par)) % 2) == 1);
    return e;
  endfunction

  initial begin
    baud_uart = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      baud_uart = 1'b1;
      @(negedge clk);
      baud_uart = 1'b0;
    end
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (receiving) recv_seen = 1'b1;
      if (rx_done || frame_err || parity_err) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: got d_out=%h done=%b ferr=%b perr=%b want no strobe",
                   d_out, rx_done, frame_err, parity_err);
        end else begin
          mon_e = exp_q.pop_front();
          check("d_out", d_out, mon_e.data);
          check("rx_done", rx_done, mon_e.done);
          check("frame_err", frame_err, mon_e.ferr);
          check("parity_err", parity_err, mon_e.perr);
          check("recv_falls_with_strobe", receiving, 0);
          check("recv_before_strobe", prev_recv, 1);
          lat = cyc - start_cyc;
          total++;
          if (lat < NB * BIT_CLK + 16 || lat > NB * BIT_CLK + 56) begin
            bad++;
            $display("FAIL latency: got %0d clk want %0d..%0d", lat,
                     NB * BIT_CLK + 16, NB * BIT_CLK + 56);
          end
        end
      end
      prev_recv = receiving;
    end
  end

  task automatic hold(input logic v, input int n);
    rxd = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input bit par_bad, input bit stop, input int gap);
    hold(1'b1, gap);
    start_cyc = cyc;
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) hold(data[i], BIT_CLK);
    if (PAR_EN) hold(^data ^ par_bad, BIT_CLK);
    hold(stop, BIT_CLK);
  endtask

  task automatic partial_frame(input logic [7:0] data);
    hold(1'b1, 20);
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) hold(data[i], BIT_CLK);
    hold(data[4], BIT_CLK / 2);
  endtask

  vec_t vecs[8];
  bit   last_stop;
  exp_t e;
  int   gap;

  initial begin
    vecs[0] = '{8'h70, 1'b0, 1'b1, 20, 8'h70, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h70, 1'b1, 1'b1, 20, 8'h70, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'hA5, 1'b0, 1'b0, 20, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 1'b0, 1'b1, 40, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b1,  0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h3C, 1'b0, 1'b1,  0, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h81, 1'b1, 1'b1, 16, 8'h81, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{8'h5A, 1'b1, 1'b0, 16, 8'h5A, 1'b0, 1'b1, 1'b1};

    rst = 1'b1;
    enable_rx = 1'b0;
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_d_out", d_out, 0);
    check("reset_rx_done", rx_done, 0);
    check("reset_receiving", receiving, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_parity_err", parity_err, 0);
    rst = 1'b0;
    enable_rx = 1'b1;
    hold(1'b1, 40);

    foreach (vecs[i]) begin
      e.data = vecs[i].exp_d;
      e.done = vecs[i].exp_done;
      e.ferr = vecs[i].exp_ferr;
      e.perr = vecs[i].exp_perr & PAR_EN;
      exp_q.push_back(e);
      send_frame(vecs[i].data, vecs[i].par_bad, vecs[i].stop, vecs[i].gap);
    end
    hold(1'b1, BIT_CLK);
    check("table_drained", exp_q.size(), 0);

    // Short low glitch on an idle line must not start a frame.
    hold(1'b1, 100);
    recv_seen = 1'b0;
    hold(1'b0, 12);
    hold(1'b1, 300);
    check("glitch_recv_seen", recv_seen, 0);
    check("glitch_receiving", receiving, 0);

    // Framing error followed by a stuck-low line.
    exp_q.push_back(model(8'hA5, 1'b0, 1'b0));
    send_frame(8'hA5, 1'b0, 1'b0, 20);
    recv_seen = 1'b0;
    hold(1'b0, 20 * BIT_CLK);
    check("break_recv_seen", recv_seen, 0);
    check("break_d_out", d_out, 8'hA5);
    exp_q.push_back(model(8'h3C, 1'b0, 1'b1));
    send_frame(8'h3C, 1'b0, 1'b1, 30);
    hold(1'b1, BIT_CLK);
    check("break_drained", exp_q.size(), 0);

    // Reset during data bit 4.
    partial_frame(8'hC3);
    check("rst_recv_mid", receiving, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_d_out", d_out, 0);
    check("rst_mid_receiving", receiving, 0);
    check("rst_mid_rx_done", rx_done, 0);
    check("rst_mid_frame_err", frame_err, 0);
    hold(1'b1, 10);
    rst = 1'b0;
    hold(1'b1, 100);
    exp_q.push_back(model(8'h3C, 1'b0, 1'b1));
    send_frame(8'h3C, 1'b0, 1'b1, 10);
    hold(1'b1, BIT_CLK);
    check("rst_drained", exp_q.size(), 0);

    // Enable dropped during data bit 4.
    partial_frame(8'h96);
    check("en_recv_mid", receiving, 1);
    enable_rx = 1'b0;
    hold(1'b1, 2);
    check("en_low_receiving", receiving, 0);
    hold(1'b1, 100);
    enable_rx = 1'b1;
    hold(1'b1, 700);
    check("en_d_out_held", d_out, 8'h3C);
    exp_q.push_back(model(8'h3C, 1'b0, 1'b1));
    send_frame(8'h3C, 1'b0, 1'b1, 10);
    hold(1'b1, BIT_CLK);
    check("en_drained", exp_q.size(), 0);

    // Random frames, including back-to-back and error cases.
    last_stop = 1'b1;
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      bit         pb, sb;
      d  = 8'($urandom);
      pb = ($urandom_range(0, 3) == 0);
      sb = ($urandom_range(0, 5) != 0);
      if (!last_stop)                    gap = int'($urandom_range(8, 80));
      else if ($urandom_range(0, 1) == 0) gap = 0;
      else                               gap = int'($urandom_range(1, 100));
      exp_q.push_back(model(d, pb, sb));
      send_frame(d, pb, sb, gap);
      last_stop = sb;
    end
    hold(1'b1, 2 * BIT_CLK);
    check("random_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: the receive-side counterpart of `uart_tx`, completing the serial link of the prescaler-driven UART. It samples the asynchronous `rxd` line using the shared 16x-oversampled baud tick and deframes 8N1 characters, LSB first. It delivers each byte on `d_out` with a one-cycle `rx_done` strobe. Start-bit glitches are rejected and bad stop bits are flagged.

## Interface
Parameters:
- `OVERSAMPLE`, 16: baud ticks per bit. Must be even and ≥ 4.
- `DATA_BITS`, 8: data bits per frame.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `baud_uart`  in  1  one-`clk`-wide tick at `OVERSAMPLE` × baud rate, from the prescaler.
- `enable_rx`  in  1  active-high. When low, the FSM is forced to IDLE and no strobes are issued.
- `rxd`  in  1  asynchronous serial input; idle high.
- `d_out`  out  DATA_BITS  last received byte; holds until the next frame completes.
- `rx_done`  out  1  one-`clk` pulse: valid byte on `d_out`.
- `receiving`  out  1  high from start-bit validation until return to IDLE.
- `frame_err`  out  1  one-`clk` pulse: stop bit sampled low.
- `parity_err`  out  1  one-`clk` pulse: parity mismatch (see Configuration).

## Operation
- Input sync: `rxd` passes through a 2-FF synchronizer, preset to 1 on reset, giving `rxd_s`. A third register holds the previous value for falling-edge detection.
- Counters:
  - `tick_cnt` is log2(OVERSAMPLE) bits wide and advances only on `baud_uart`.
  - `bit_cnt` is log2(DATA_BITS)+1 bits wide.
- FSM states and transitions:
  - IDLE: `tick_cnt`=0. A falling edge on `rxd_s` moves to START.
  - START: count `OVERSAMPLE/2` ticks to mid-bit.
    - If `rxd_s`=1 at mid-bit, it was a glitch: return to IDLE with no strobe.
    - If `rxd_s`=0, clear `tick_cnt`, assert `receiving`, and go to DATA.
  - DATA: every `OVERSAMPLE` ticks, sample `rxd_s` into shift register bit `bit_cnt` (LSB first). After `DATA_BITS` samples, go to PARITY (macro defined) or STOP.
  - PARITY: one bit-time, then sample the parity bit; go to STOP.
  - STOP: one bit-time, then sample the stop bit.
    - If sampled 1: load `d_out` and pulse `rx_done`.
    - If sampled 0: load `d_out` and pulse `frame_err`; no `rx_done`.
    - Either way, return to IDLE.
- Error strobes: `parity_err` pulses together with the STOP outcome strobe (`rx_done` or `frame_err`) if the parity check failed. Both `rx_done` and `parity_err` may pulse in the same cycle.
- Break/stuck-low line: after a `frame_err`, the next frame cannot start until `rxd_s` returns high, because edge detection requires a high-to-low transition.
- `enable_rx` low: forces IDLE, clears the counters and `receiving`. `d_out` is retained.
- Reset values: `d_out`=0, `rx_done`=0, `receiving`=0, `frame_err`=0, `parity_err`=0, FSM=IDLE, synchronizer=1.
- Reset mid-frame: abort immediately with no strobe.

## Timing
- Input latency: `rxd` to `rxd_s` is 2 `clk` cycles.
- Edge detect: one further cycle.
- Sample points:
  - Start bit at tick `OVERSAMPLE/2` after the edge.
  - Each subsequent bit `OVERSAMPLE` ticks later, which is mid-bit.
- Strobe timing:
  - `rx_done`, `frame_err` and `parity_err` assert in the `clk` cycle after the `baud_uart` tick that samples the stop bit. Each lasts exactly 1 `clk`.
  - `d_out` updates in that same cycle.
- `receiving`:
  - Rises the cycle after start validation.
  - Falls in the same cycle the completion strobe asserts.
- Ticks: `baud_uart` is ignored while IDLE except for edge detection. Ticks arriving on consecutive `clk` cycles are each counted.
- Back-to-back frames: the FSM is in IDLE half a bit before the nominal stop-bit end. A start edge arriving immediately after the stop bit is therefore caught.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- Defined:
  - Frame is 8E1: an even-parity bit follows the data bits, and the PARITY state is used.
  - `parity_err` pulses when XOR(data bits, parity bit) = 1.
- Undefined:
  - Frame is 8N1 and the PARITY state is not built.
  - `parity_err` is tied to 0.

## Test plan
Bench setup: `baud_uart` ticks every 4 `clk`, so 1 bit = 64 `clk`.
- Reset, then `enable_rx`=1. Send 8N1 frame 0x70 → `d_out`=0x70 and one `rx_done` pulse about 10 bit-times after the start edge. `frame_err`=0 and `receiving` is high throughout the frame.
- Drive a 3-tick low glitch on an idle line → no `rx_done`, `receiving` never rises, FSM back in IDLE.
- Send 0xA5 with stop bit = 0 → `frame_err` pulses once, `d_out`=0xA5, no `rx_done`. With the line held low afterwards, no new frame starts until `rxd` returns high.
- Send 0x00 then 0xFF back-to-back with no idle gap → two `rx_done` pulses, with `d_out` reading 0x00 then 0xFF.
- Mid-frame aborts, each followed by sending 0x3C → only 0x3C is reported:
  - Assert `rst` during bit 4 → all outputs 0 immediately.
  - Drop `enable_rx` during bit 4 → no strobe.
- With `UART_RX_PARITY_EN` defined:
  - Send 0x70 with parity bit 1 → `rx_done`, no `parity_err`.
  - Send 0x70 with parity bit 0 → `rx_done` and `parity_err` in the same cycle.
